// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle ARM-subset datapath.
// Sequences fetch/decode/execute/memory/writeback and emits the unconditioned
// write intents plus the datapath mux selects and ALU control. All outputs are
// registered: each edge loads the control word of the state being entered.
module multicycle_main_fsm (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic [1:0] FlagW,
    output logic       NoWrite,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StFetch    = 4'd1,
        StDecode   = 4'd2,
        StMemAdr   = 4'd3,
        StMemRead  = 4'd4,
        StMemWb    = 4'd5,
        StMemWrite = 4'd6,
        StExecuteR = 4'd7,
        StExecuteI = 4'd8,
        StAluWb    = 4'd9,
        StBranch   = 4'd10
    } state_e;

    typedef struct packed {
        logic       ir_write;
        logic       next_pc;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_control;
        logic       pcs;
        logic       reg_w;
        logic       mem_w;
        logic [1:0] flag_w;
        logic       no_write;
    } ctrl_t;

    localparam logic [3:0] CmdAnd = 4'b0000;
    localparam logic [3:0] CmdSub = 4'b0010;
    localparam logic [3:0] CmdAdd = 4'b0100;
    localparam logic [3:0] CmdCmp = 4'b1010;
    localparam logic [3:0] CmdOrr = 4'b1100;

    state_e cur_state;
    state_e state_next;
    ctrl_t  ctrl;
    ctrl_t  ctrl_next;

    // Successor of a state; undefined encodings recover to FETCH.
    function automatic state_e next_of(input state_e st, input logic [1:0] op,
                                       input logic [5:0] funct);
        state_e ns;
        ns = StFetch;
        case (st)
            StIdle:     ns = StFetch;
            StFetch:    ns = StDecode;
            StDecode: begin
                case (op)
                    2'b00:   ns = funct[5] ? StExecuteI : StExecuteR;
                    2'b01:   ns = StMemAdr;
                    2'b10:   ns = StBranch;
                    default: ns = StFetch;
                endcase
            end
            StMemAdr:   ns = funct[0] ? StMemRead : StMemWrite;
            StMemRead:  ns = StMemWb;
            StExecuteR: ns = StAluWb;
            StExecuteI: ns = StAluWb;
            StMemWb:    ns = StFetch;
            StMemWrite: ns = StFetch;
            StAluWb:    ns = StFetch;
            StBranch:   ns = StFetch;
            default:    ns = StFetch;
        endcase
        return ns;
    endfunction

    // ALU decode for the EXECUTE states: returns {ALUControl, FlagW}.
    function automatic logic [3:0] alu_decode(input logic [5:0] funct);
        logic [3:0] cmd;
        logic [1:0] alu;
        logic       known;
        logic       arith;
        cmd   = funct[4:1];
        alu   = 2'b00;
        known = 1'b1;
        arith = 1'b0;
        case (cmd)
            CmdAdd: begin alu = 2'b00; arith = 1'b1; end
            CmdSub: begin alu = 2'b01; arith = 1'b1; end
            CmdAnd: alu = 2'b10;
            CmdOrr: alu = 2'b11;
            CmdCmp: begin alu = 2'b01; arith = 1'b1; end
            default: known = 1'b0;
        endcase
        // Only arithmetic ops update C/V; unsupported commands write no flags.
        return {alu, (known && funct[0]) ? {1'b1, arith} : 2'b00};
    endfunction

    // Control word for a state, given the instruction fields held stable in IR.
    function automatic ctrl_t ctrl_for(input state_e st, input logic [5:0] funct,
                                       input logic [3:0] rd);
        ctrl_t c;
        logic  is_cmp;
        c      = '0;
        is_cmp = (funct[4:1] == CmdCmp);
        case (st)
            StFetch: begin
                c.ir_write   = 1'b1;
                c.next_pc    = 1'b1;
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            StDecode: begin
                // PC+8 is formed here so R15 reads correctly in later states.
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            StMemAdr: begin
                c.alu_src_b = 2'b01;
            end
            StMemRead: begin
                c.adr_src = 1'b1;
            end
            StMemWb: begin
                c.result_src = 2'b01;
                c.reg_w      = 1'b1;
                c.pcs        = (rd == 4'hF);
            end
            StMemWrite: begin
                c.adr_src = 1'b1;
                c.mem_w   = 1'b1;
            end
            StExecuteR: begin
                c.alu_src_b                = 2'b00;
                {c.alu_control, c.flag_w}  = alu_decode(funct);
            end
            StExecuteI: begin
                c.alu_src_b                = 2'b01;
                {c.alu_control, c.flag_w}  = alu_decode(funct);
            end
            StAluWb: begin
                c.reg_w    = 1'b1;
                c.no_write = is_cmp;
                // A suppressed CMP write must not redirect the PC either.
                c.pcs      = (rd == 4'hF) && !is_cmp;
            end
            StBranch: begin
                c.alu_src_b  = 2'b01;
                c.result_src = 2'b10;
                c.pcs        = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next state and the control word that goes with it.
    always_comb begin
        state_next = next_of(cur_state, Op, Funct);
        ctrl_next  = ctrl_for(state_next, Funct, Rd);
    end

    // State and registered outputs; reset forces IDLE with every output low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur_state <= StIdle;
            ctrl      <= '0;
        end else begin
            cur_state <= state_next;
            ctrl      <= ctrl_next;
        end
    end

    assign IRWrite    = ctrl.ir_write;
    assign NextPC     = ctrl.next_pc;
    assign AdrSrc     = ctrl.adr_src;
    assign ALUSrcA    = ctrl.alu_src_a;
    assign ALUSrcB    = ctrl.alu_src_b;
    assign ResultSrc  = ctrl.result_src;
    assign ALUControl = ctrl.alu_control;
    assign PCS        = ctrl.pcs;
    assign RegW       = ctrl.reg_w;
    assign MemW       = ctrl.mem_w;
    assign FlagW      = ctrl.flag_w;
    assign NoWrite    = ctrl.no_write;
    assign state      = cur_state;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm: walks instruction classes cycle by
// cycle and compares state plus the full packed output word against
// hand-computed constants.
module tb_multicycle_main_fsm;

    logic       clk;
    logic       reset_n;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       IRWrite, NextPC, AdrSrc, ALUSrcA, PCS, RegW, MemW, NoWrite;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl, FlagW;
    logic [3:0] state;
    logic [15:0] outs;

    int checks = 0;
    int errors = 0;

    multicycle_main_fsm dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .IRWrite    (IRWrite),
        .NextPC     (NextPC),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .FlagW      (FlagW),
        .NoWrite    (NoWrite),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: IRWrite NextPC AdrSrc ALUSrcA ALUSrcB ResultSrc ALUControl PCS RegW MemW FlagW NoWrite
    assign outs = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
                   PCS, RegW, MemW, FlagW, NoWrite};

    function automatic logic [15:0] pk(input logic irw, input logic npc, input logic adr,
                                       input logic sa, input logic [1:0] sb,
                                       input logic [1:0] res, input logic [1:0] alu,
                                       input logic pcs, input logic rw, input logic mw,
                                       input logic [1:0] fw, input logic nw);
        return {irw, npc, adr, sa, sb, res, alu, pcs, rw, mw, fw, nw};
    endfunction

    localparam logic [15:0] OutZero  = 16'h0000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] exp_state,
                       input logic [15:0] exp_outs);
        checks++;
        assert (state === exp_state) else begin
            errors++;
            $display("FAIL %s state observed %0d expected %0d", tag, state, exp_state);
            $error("check %s state", tag);
        end
        checks++;
        assert (outs === exp_outs) else begin
            errors++;
            $display("FAIL %s outputs observed %b expected %b", tag, outs, exp_outs);
            $error("check %s outputs", tag);
        end
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [5:0] funct,
                             input logic [3:0] rd);
        Op    = op;
        Funct = funct;
        Rd    = rd;
    endtask

    initial begin
        logic [15:0] o_fetch, o_decode;
        o_fetch  = pk(1, 1, 0, 1, 2'b10, 2'b10, 2'b00, 0, 0, 0, 2'b00, 0);
        o_decode = pk(0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 0, 0, 0, 2'b00, 0);

        reset_n = 1'b0;
        set_instr(2'b00, 6'b000000, 4'h0);

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset", 4'd0, OutZero);
        end
        reset_n = 1'b1;
        tick();
        chk("first_fetch", 4'd1, o_fetch);

        // ADDS r3, register operand.
        set_instr(2'b00, 6'b001001, 4'h3);
        tick(); chk("adds_decode", 4'd2, o_decode);
        tick(); chk("adds_exec", 4'd7, pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b11, 0));
        tick(); chk("adds_wb", 4'd9, pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b00, 0));
        tick(); chk("adds_fetch", 4'd1, o_fetch);

        // CMP immediate with Rd=15: PC write must stay suppressed.
        set_instr(2'b00, 6'b110101, 4'hF);
        tick(); chk("cmp_decode", 4'd2, o_decode);
        tick(); chk("cmp_exec", 4'd8, pk(0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 0, 0, 0, 2'b11, 0));
        tick(); chk("cmp_wb", 4'd9, pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b00, 1));
        tick(); chk("cmp_fetch", 4'd1, o_fetch);

        // ORR (no S) to PC: ALU 11, no flags, PCS in writeback.
        set_instr(2'b00, 6'b011000, 4'hF);
        tick(); chk("orr_decode", 4'd2, o_decode);
        tick(); chk("orr_exec", 4'd7, pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 2'b00, 0));
        tick(); chk("orr_wb", 4'd9, pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 2'b00, 0));
        tick(); chk("orr_fetch", 4'd1, o_fetch);

        // ANDS register: logical op writes NZ only.
        set_instr(2'b00, 6'b000001, 4'h1);
        tick(); chk("ands_decode", 4'd2, o_decode);
        tick(); chk("ands_exec", 4'd7, pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0, 0, 0, 2'b10, 0));
        tick(); chk("ands_wb", 4'd9, pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b00, 0));
        tick(); chk("ands_fetch", 4'd1, o_fetch);

        // SUB immediate without S.
        set_instr(2'b00, 6'b100100, 4'h2);
        tick(); chk("sub_decode", 4'd2, o_decode);
        tick(); chk("sub_exec", 4'd8, pk(0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 0, 0, 0, 2'b00, 0));
        tick(); chk("sub_wb", 4'd9, pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b00, 0));
        tick(); chk("sub_fetch", 4'd1, o_fetch);

        // Unsupported cmd 1101 with S: ADD control, no flag writes.
        set_instr(2'b00, 6'b011011, 4'h4);
        tick(); chk("mov_decode", 4'd2, o_decode);
        tick(); chk("mov_exec", 4'd7, pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tick(); chk("mov_wb", 4'd9, pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b00, 0));
        tick(); chk("mov_fetch", 4'd1, o_fetch);

        // LDR to PC.
        set_instr(2'b01, 6'b011001, 4'hF);
        tick(); chk("ldr_decode", 4'd2, o_decode);
        tick(); chk("ldr_adr", 4'd3, pk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tick(); chk("ldr_read", 4'd4, pk(0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tick(); chk("ldr_wb", 4'd5, pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 1, 1, 0, 2'b00, 0));
        tick(); chk("ldr_fetch", 4'd1, o_fetch);

        // STR.
        set_instr(2'b01, 6'b011000, 4'h2);
        tick(); chk("str_decode", 4'd2, o_decode);
        tick(); chk("str_adr", 4'd3, pk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tick(); chk("str_write", 4'd6, pk(0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b00, 0));
        tick(); chk("str_fetch", 4'd1, o_fetch);

        // B: back in FETCH three cycles after its own FETCH.
        set_instr(2'b10, 6'b101000, 4'h0);
        tick(); chk("b_decode", 4'd2, o_decode);
        tick(); chk("b_branch", 4'd10, pk(0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 1, 0, 0, 2'b00, 0));
        tick(); chk("b_fetch", 4'd1, o_fetch);

        // Undefined op: DECODE straight back to FETCH.
        set_instr(2'b11, 6'b111111, 4'hF);
        tick(); chk("undef_decode", 4'd2, o_decode);
        tick(); chk("undef_fetch", 4'd1, o_fetch);

        // Reset during MEMREAD aborts the load: no RegW pulse follows.
        set_instr(2'b01, 6'b011001, 4'h5);
        tick(); chk("abort_decode", 4'd2, o_decode);
        tick(); chk("abort_adr", 4'd3, pk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tick(); chk("abort_read", 4'd4, pk(0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        reset_n = 1'b0;
        tick(); chk("abort_reset", 4'd0, OutZero);
        tick(); chk("abort_hold", 4'd0, OutZero);
        reset_n = 1'b1;
        tick(); chk("abort_refetch", 4'd1, o_fetch);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
